// File: rtl/load_store_unit.sv
// Load/store unit: turns one-cycle load/store requests from the control unit
// into a single memory handshake, with lane steering, load extension,
// alignment/funct3 checking and a bounded wait for mem_ready.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_reg_we,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_err_code,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_is_store;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [CW-1:0] r_wait_cnt;
  logic [31:0]   r_rdata;
  logic [1:0]    r_err_code;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_wdata;

  logic          w_illegal;
  logic          w_misaligned;
  logic          w_wait_expired;
  logic [3:0]    w_be;
  logic [31:0]   w_store_data;
  logic [31:0]   w_lane;
  logic [31:0]   w_load_ext;

  assign w_wait_expired = (r_wait_cnt == CW'(TIMEOUT_CYC - 1));

  // Classify the incoming request: illegal funct3 takes priority over alignment.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    case (i_funct3)
      3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
      3'b100, 3'b101:         w_illegal = i_is_store;
      default:                w_illegal = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b01:   w_misaligned = i_addr[0];
      2'b10:   w_misaligned = (i_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    if (w_illegal) begin
      w_misaligned = 1'b0;
    end
  end

  // Store lane steering: replicate the data across lanes and pick byte enables.
  always_comb begin
    w_be         = 4'b0000;
    w_store_data = 32'h0;
    if (i_is_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          w_be         = 4'b0001 << i_addr[1:0];
          w_store_data = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          w_be         = 4'b0011 << i_addr[1:0];
          w_store_data = {2{i_wdata[15:0]}};
        end
        default: begin
          w_be         = 4'b1111;
          w_store_data = i_wdata;
        end
      endcase
    end
  end

  // Load lane selection and sign/zero extension of the returned word.
  always_comb begin
    w_lane     = i_mem_rdata >> {r_addr[1:0], 3'b000};
    w_load_ext = w_lane;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'h0, w_lane[7:0]};
      3'b101:  w_load_ext = {16'h0, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Next-state logic: errors bypass memory entirely, REQ waits for ready or timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (w_illegal || w_misaligned) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (i_mem_ready) begin
          w_next_state = S_RESP;
        end else if (w_wait_expired) begin
          w_next_state = S_ERR;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      S_ERR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture, wait counter, error code and load result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wait_cnt  <= '0;
      r_rdata     <= 32'h0;
      r_err_code  <= ERR_OK;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_is_store  <= i_is_store;
            r_funct3    <= i_funct3;
            r_addr      <= i_addr;
            r_wait_cnt  <= '0;
            r_mem_be    <= w_be;
            r_mem_wdata <= w_store_data;
            if (w_illegal) begin
              r_err_code <= ERR_ILLEGAL;
            end else if (w_misaligned) begin
              r_err_code <= ERR_MISALIGN;
            end else begin
              r_err_code <= ERR_OK;
            end
          end
        end
        S_REQ: begin
          if (i_mem_ready) begin
            r_err_code <= ERR_OK;
            if (!r_is_store) begin
              r_rdata <= w_load_ext;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_wait_expired) begin
              r_err_code <= ERR_TIMEOUT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_RESP) || (r_state == S_ERR);
  assign o_reg_we    = (r_state == S_RESP) && !r_is_store;
  assign o_rdata     = r_rdata;
  assign o_err_code  = r_err_code;
  assign o_mem_req   = (r_state == S_REQ);
  assign o_mem_we    = (r_state == S_REQ) && r_is_store;
  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against a behavioural model built from plain arithmetic.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        memReady = 1'b0;
  logic [31:0] memRdata = 32'h0;
  logic        busy;
  logic        done;
  logic        regWe;
  logic [31:0] rdata;
  logic [1:0]  errCode;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelRdata = 32'h0;

  load_store_unit #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_start     (start),
    .i_is_store  (isStore),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_reg_we    (regWe),
    .o_rdata     (rdata),
    .o_err_code  (errCode),
    .o_mem_req   (memReq),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_be    (memBe),
    .o_mem_wdata (memWdata),
    .i_mem_ready (memReady),
    .i_mem_rdata (memRdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int accessBytes(input logic [2:0] f3);
    int sz;
    sz = f3 % 4;
    if (sz == 0) return 1;
    if (sz == 1) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] refErr(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7 || (st && (f3 == 4 || f3 == 5))) return 2'd2;
    if ((a % accessBytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] refBe(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!st) return 32'd0;
    n = accessBytes(f3);
    if (n == 4) return 32'd15;
    return ((1 << n) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] w);
    int n;
    n = accessBytes(f3);
    if (n == 1) return (w % 256) * 32'h0101_0101;
    if (n == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> (8 * (a % 4));
    case (f3)
      3'd0: begin
        v = sh % 256;
        return (v >= 128) ? v + 32'hFFFF_FF00 : v;
      end
      3'd1: begin
        v = sh % 65536;
        return (v >= 32768) ? v + 32'hFFFF_0000 : v;
      end
      3'd4:    return sh % 256;
      3'd5:    return sh % 65536;
      default: return sh;
    endcase
  endfunction

  // Issues one request at the current negedge, serves memory after waitCycles
  // stall cycles, checks the bus and the completion, and returns at the next
  // idle negedge so a following call lands in the cycle right after done.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int waitCycles, input logic [31:0] word);
    logic [1:0] expErr;
    int expLatency;
    int expReqCycles;
    int cyc;
    int reqCycles;
    bit seenDone;
    expErr = refErr(st, f3, a);
    if (expErr != 0) begin
      expLatency   = 1;
      expReqCycles = 0;
    end else if (waitCycles >= TIMEOUT) begin
      expErr       = 2'd3;
      expLatency   = TIMEOUT + 1;
      expReqCycles = TIMEOUT;
    end else begin
      expLatency   = waitCycles + 2;
      expReqCycles = waitCycles + 1;
    end
    start    = 1'b1;
    isStore  = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    memReady = 1'b0;
    cyc       = 0;
    reqCycles = 0;
    seenDone  = 1'b0;
    while (!seenDone && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      memReady = 1'b0;
      memRdata = $urandom;
      if (memReq) begin
        reqCycles++;
        checkOutput("memAddr", memAddr, a - (a % 4));
        checkOutput("memWe", {31'd0, memWe}, {31'd0, st});
        checkOutput("memBe", {28'd0, memBe}, refBe(st, f3, a));
        if (st) checkOutput("memWdata", memWdata, refWdata(f3, wd));
        checkOutput("busyInReq", {31'd0, busy}, 32'd1);
        if (reqCycles == waitCycles + 1) begin
          memReady = 1'b1;
          memRdata = word;
        end
      end
      if (done) begin
        seenDone = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        start   = 1'b1;
        isStore = 1'($urandom);
        funct3  = 3'($urandom);
        addr    = $urandom;
        wdata   = $urandom;
      end
    end
    start    = 1'b0;
    memReady = 1'b0;
    checkOutput("doneSeen", {31'd0, seenDone}, 32'd1);
    checkOutput("latency", cyc, expLatency);
    checkOutput("reqCycles", reqCycles, expReqCycles);
    checkOutput("errCode", {30'd0, errCode}, {30'd0, expErr});
    checkOutput("regWe", {31'd0, regWe}, (expErr == 0 && !st) ? 32'd1 : 32'd0);
    checkOutput("memReqAtDone", {31'd0, memReq}, 32'd0);
    checkOutput("busyAtDone", {31'd0, busy}, 32'd1);
    if (expErr == 0 && !st) modelRdata = refLoad(f3, a, word);
    checkOutput("rdata", rdata, modelRdata);
    @(negedge clk);
    checkOutput("donePulse", {31'd0, done}, 32'd0);
    checkOutput("busyIdle", {31'd0, busy}, 32'd0);
    checkOutput("rdataHold", rdata, modelRdata);
  endtask

  // Main sequence: reset checks, directed cases, mid-request reset, random traffic.
  initial begin
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    int w;
    #12;
    checkOutput("rstMemReq", {31'd0, memReq}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstRegWe", {31'd0, regWe}, 32'd0);
    checkOutput("rstMemWe", {31'd0, memWe}, 32'd0);
    checkOutput("rstMemBe", {28'd0, memBe}, 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'd0);
    checkOutput("rstMemWdata", memWdata, 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    checkOutput("rstErrCode", {30'd0, errCode}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(1'b0, 3'd0, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    applyStimulus(1'b0, 3'd5, 32'h0000_0202, 32'h0, 3, 32'hBEEF_0000);
    applyStimulus(1'b1, 3'd1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0);
    applyStimulus(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00AB, 1, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0102, 32'h0, 0, 32'h0);
    applyStimulus(1'b0, 3'd3, 32'h0000_0100, 32'h0, 0, 32'h0);
    applyStimulus(1'b1, 3'd4, 32'h0000_0100, 32'h0, 0, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0040, 32'h0, 100, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0044, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);

    start   = 1'b1;
    isStore = 1'b0;
    funct3  = 3'd2;
    addr    = 32'h0000_0080;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midReqActive", {31'd0, memReq}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midRstMemReq", {31'd0, memReq}, 32'd0);
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstRdata", rdata, 32'd0);
    modelRdata = 32'h0;
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("noDoneAfterRst", {31'd0, done}, 32'd0);
    end

    for (int n = 0; n < 250; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a - (a % 4);
      w  = ($urandom_range(0, 15) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 4));
      applyStimulus(st, f3, a, $urandom, w, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
